// File: rtl/branch_pred_unit.sv
// Next-PC unit: direct-mapped BTB with 2-bit counters for fetch, and branch resolution/training for execute.
// Optional BRANCH_PRED_PERF_EN adds branch and mispredict performance counters.
module branch_pred_unit #(
  parameter  int XLEN    = 32,
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int TAG_W   = XLEN - 2 - IDX_W
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [XLEN-1:0] F_PC,
  output logic            F_PRED_TAKEN,
  output logic [XLEN-1:0] F_PRED_TARGET,
  input  logic            R_VALID,
  input  logic [6:0]      R_OPCODE,
  input  logic [2:0]      R_FUNCT,
  input  logic            R_BR_EQ,
  input  logic            R_BR_LT,
  input  logic            R_BR_LTU,
  input  logic [XLEN-1:0] R_PC,
  input  logic [XLEN-1:0] R_TARGET,
  input  logic            R_PRED_TAKEN,
  input  logic [XLEN-1:0] R_PRED_TARGET,
  output logic [2:0]      R_PC_SOURCE,
  output logic            R_MISPREDICT,
  output logic [XLEN-1:0] R_REDIRECT_PC
`ifdef BRANCH_PRED_PERF_EN
  ,
  output logic [31:0]     PERF_BR_CNT,
  output logic [31:0]     PERF_MISS_CNT
`endif
);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] SRC_SEQ  = 3'b000;
  localparam logic [2:0] SRC_JALR = 3'b001;
  localparam logic [2:0] SRC_BR   = 3'b010;
  localparam logic [2:0] SRC_JAL  = 3'b011;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  logic             v_q   [ENTRIES];
  logic [TAG_W-1:0] tag_q [ENTRIES];
  logic [XLEN-1:0]  tgt_q [ENTRIES];
  logic [1:0]       ctr_q [ENTRIES];

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;
  logic [XLEN-1:0]  f_seq_pc;

  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  logic             r_hit;
  logic [XLEN-1:0]  r_seq_pc;

  logic is_jal;
  logic is_jalr;
  logic is_br;
  logic br_cond;
  logic resolve_vld;
  logic act_taken;
  logic train_taken;
  logic train_nt;

  // Fetch-side lookup against the registered table
  always_comb begin
    f_idx         = F_PC[IDX_W+1:2];
    f_tag         = F_PC[XLEN-1:IDX_W+2];
    f_seq_pc      = F_PC + XLEN'(4);
    f_hit         = v_q[f_idx] && (tag_q[f_idx] == f_tag);
    F_PRED_TAKEN  = !RST && f_hit && ctr_q[f_idx][1];
    F_PRED_TARGET = F_PRED_TAKEN ? tgt_q[f_idx] : f_seq_pc;
  end

  // Execute-side resolution; funct3 010/011 are not real branches and are ignored
  always_comb begin
    is_jal  = (R_OPCODE == OP_JAL);
    is_jalr = (R_OPCODE == OP_JALR);
    is_br   = (R_OPCODE == OP_BRANCH) && (R_FUNCT[2:1] != 2'b01);
    br_cond = 1'b0;
    case (R_FUNCT)
      3'b000:  br_cond = R_BR_EQ;
      3'b001:  br_cond = !R_BR_EQ;
      3'b100:  br_cond = R_BR_LT;
      3'b101:  br_cond = !R_BR_LT;
      3'b110:  br_cond = R_BR_LTU;
      3'b111:  br_cond = !R_BR_LTU;
      default: br_cond = 1'b0;
    endcase

    resolve_vld = R_VALID && (is_jal || is_jalr || is_br);
    act_taken   = resolve_vld && (is_jal || is_jalr || br_cond);

    R_PC_SOURCE = SRC_SEQ;
    if (R_VALID) begin
      if (is_jal)                R_PC_SOURCE = SRC_JAL;
      else if (is_jalr)          R_PC_SOURCE = SRC_JALR;
      else if (is_br && br_cond) R_PC_SOURCE = SRC_BR;
    end

    r_seq_pc      = R_PC + XLEN'(4);
    R_MISPREDICT  = resolve_vld &&
                    ((act_taken != R_PRED_TAKEN) ||
                     (act_taken && (R_PRED_TARGET != R_TARGET)));
    R_REDIRECT_PC = '0;
    if (R_MISPREDICT)
      R_REDIRECT_PC = act_taken ? R_TARGET : r_seq_pc;

    r_idx       = R_PC[IDX_W+1:2];
    r_tag       = R_PC[XLEN-1:IDX_W+2];
    r_hit       = v_q[r_idx] && (tag_q[r_idx] == r_tag);
    train_taken = act_taken;
    train_nt    = resolve_vld && !act_taken;
  end

  // Table update: taken allocates/strengthens, not-taken weakens an existing entry only
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        v_q[i]   <= 1'b0;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= 2'b01;
      end
    end else if (train_taken) begin
      v_q[r_idx]   <= 1'b1;
      tag_q[r_idx] <= r_tag;
      tgt_q[r_idx] <= R_TARGET;
      ctr_q[r_idx] <= r_hit ? sat_inc(ctr_q[r_idx]) : 2'b10;
    end else if (train_nt && r_hit) begin
      ctr_q[r_idx] <= sat_dec(ctr_q[r_idx]);
    end
  end

`ifdef BRANCH_PRED_PERF_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PERF_BR_CNT   <= '0;
      PERF_MISS_CNT <= '0;
    end else begin
      if (resolve_vld)  PERF_BR_CNT   <= PERF_BR_CNT + 32'd1;
      if (R_MISPREDICT) PERF_MISS_CNT <= PERF_MISS_CNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_pred_unit.sv
// Directed bench for branch_pred_unit (ENTRIES=16, XLEN=32) with hand-computed expectations.
module tb_branch_pred_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] F_PC;
  logic        F_PRED_TAKEN;
  logic [31:0] F_PRED_TARGET;
  logic        R_VALID;
  logic [6:0]  R_OPCODE;
  logic [2:0]  R_FUNCT;
  logic        R_BR_EQ, R_BR_LT, R_BR_LTU;
  logic [31:0] R_PC, R_TARGET, R_PRED_TARGET;
  logic        R_PRED_TAKEN;
  logic [2:0]  R_PC_SOURCE;
  logic        R_MISPREDICT;
  logic [31:0] R_REDIRECT_PC;
`ifdef BRANCH_PRED_PERF_EN
  logic [31:0] PERF_BR_CNT, PERF_MISS_CNT;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] BR   = 7'b1100011;

  branch_pred_unit #(.XLEN(32), .ENTRIES(16)) dut (
    .CLK(CLK), .RST(RST), .F_PC(F_PC),
    .F_PRED_TAKEN(F_PRED_TAKEN), .F_PRED_TARGET(F_PRED_TARGET),
    .R_VALID(R_VALID), .R_OPCODE(R_OPCODE), .R_FUNCT(R_FUNCT),
    .R_BR_EQ(R_BR_EQ), .R_BR_LT(R_BR_LT), .R_BR_LTU(R_BR_LTU),
    .R_PC(R_PC), .R_TARGET(R_TARGET),
    .R_PRED_TAKEN(R_PRED_TAKEN), .R_PRED_TARGET(R_PRED_TARGET),
    .R_PC_SOURCE(R_PC_SOURCE), .R_MISPREDICT(R_MISPREDICT),
    .R_REDIRECT_PC(R_REDIRECT_PC)
`ifdef BRANCH_PRED_PERF_EN
    , .PERF_BR_CNT(PERF_BR_CNT), .PERF_MISS_CNT(PERF_MISS_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rs(input logic [6:0] op, input logic [2:0] f3,
                    input logic eq, input logic lt, input logic ltu,
                    input logic [31:0] pc, input logic [31:0] tgt,
                    input logic pt, input logic [31:0] ptgt);
    R_VALID = 1'b1; R_OPCODE = op; R_FUNCT = f3;
    R_BR_EQ = eq; R_BR_LT = lt; R_BR_LTU = ltu;
    R_PC = pc; R_TARGET = tgt; R_PRED_TAKEN = pt; R_PRED_TARGET = ptgt;
  endtask

  task automatic idle();
    R_VALID = 1'b0; R_OPCODE = 7'b0010011; R_FUNCT = 3'b000;
    R_BR_EQ = 1'b0; R_BR_LT = 1'b0; R_BR_LTU = 1'b0;
    R_PC = '0; R_TARGET = '0; R_PRED_TAKEN = 1'b0; R_PRED_TARGET = '0;
  endtask

  task automatic fetch(input string tag, input logic [31:0] pc,
                       input logic tk, input logic [31:0] tgt);
    F_PC = pc;
    #1;
    chk({tag, "_taken"}, 32'(F_PRED_TAKEN), 32'(tk));
    chk({tag, "_target"}, F_PRED_TARGET, tgt);
  endtask

  task automatic res(input string tag, input logic [2:0] src,
                     input logic mis, input logic [31:0] rd);
    #1;
    chk({tag, "_src"}, 32'(R_PC_SOURCE), 32'(src));
    chk({tag, "_mis"}, 32'(R_MISPREDICT), 32'(mis));
    chk({tag, "_redir"}, R_REDIRECT_PC, rd);
  endtask

  initial begin
    RST = 1'b1; F_PC = 32'h100; idle();
    #12;
    fetch("rst_fetch", 32'h100, 1'b0, 32'h104);
    res("rst_idle", 3'b000, 1'b0, 32'h0);
`ifdef BRANCH_PRED_PERF_EN
    chk("rst_perf_br", PERF_BR_CNT, 32'h0);
    chk("rst_perf_miss", PERF_MISS_CNT, 32'h0);
`endif
    @(negedge CLK); RST = 1'b0;

    // First taken BEQ allocates the entry; fetch in the same cycle still misses
    @(negedge CLK);
    rs(BR, 3'b000, 1, 0, 0, 32'h100, 32'h80, 1'b0, 32'h0);
    fetch("beq1_fetch_old", 32'h100, 1'b0, 32'h104);
    res("beq1", 3'b010, 1'b1, 32'h80);

    @(negedge CLK);
    rs(BR, 3'b000, 1, 0, 0, 32'h100, 32'h80, 1'b1, 32'h80);
    fetch("beq2_fetch", 32'h100, 1'b1, 32'h80);
    res("beq2", 3'b010, 1'b0, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    fetch("beq4_fetch", 32'h100, 1'b1, 32'h80);

    // Counter at 11: two not-taken bring it to 01
    @(negedge CLK);
    rs(BR, 3'b000, 0, 0, 0, 32'h100, 32'h80, 1'b1, 32'h80);
    res("nt1", 3'b000, 1'b1, 32'h104);
    @(negedge CLK);
    fetch("nt1_fetch", 32'h100, 1'b1, 32'h80);
    res("nt2", 3'b000, 1'b1, 32'h104);
    @(negedge CLK); idle();
    fetch("nt2_fetch", 32'h100, 1'b0, 32'h104);

    // Decrement saturates at 00, so one taken yields 01 (still not taken)
    @(negedge CLK);
    rs(BR, 3'b000, 0, 0, 0, 32'h100, 32'h80, 1'b0, 32'h0);
    res("nt3", 3'b000, 1'b0, 32'h0);
    @(negedge CLK);
    rs(BR, 3'b000, 1, 0, 0, 32'h100, 32'h80, 1'b0, 32'h0);
    res("tk_after_sat", 3'b010, 1'b1, 32'h80);
    @(negedge CLK); idle();
    fetch("sat_low_fetch", 32'h100, 1'b0, 32'h104);

    // funct3 decode at a separate index
    @(negedge CLK); rs(BR, 3'b001, 0, 0, 0, 32'h10C, 32'h20, 1'b0, 32'h0);
    res("bne", 3'b010, 1'b1, 32'h20);
    @(negedge CLK); rs(BR, 3'b100, 0, 1, 0, 32'h10C, 32'h20, 1'b0, 32'h0);
    res("blt", 3'b010, 1'b1, 32'h20);
    @(negedge CLK); rs(BR, 3'b101, 0, 1, 0, 32'h10C, 32'h20, 1'b0, 32'h0);
    res("bge", 3'b000, 1'b0, 32'h0);
    @(negedge CLK); rs(BR, 3'b110, 0, 1, 0, 32'h10C, 32'h20, 1'b0, 32'h0);
    res("bltu", 3'b000, 1'b0, 32'h0);
    @(negedge CLK); rs(BR, 3'b111, 0, 1, 0, 32'h10C, 32'h20, 1'b0, 32'h0);
    res("bgeu", 3'b010, 1'b1, 32'h20);
    @(negedge CLK); rs(BR, 3'b010, 1, 1, 1, 32'h10C, 32'h20, 1'b0, 32'h0);
    res("f3_010", 3'b000, 1'b0, 32'h0);
    @(negedge CLK); rs(7'b0110011, 3'b000, 1, 1, 1, 32'h10C, 32'h20, 1'b0, 32'h0);
    res("alu_op", 3'b000, 1'b0, 32'h0);
    @(negedge CLK); rs(JAL, 3'b000, 0, 0, 0, 32'h10C, 32'h20, 1'b0, 32'h0);
    R_VALID = 1'b0;
    res("jal_invalid", 3'b000, 1'b0, 32'h0);

    // JAL allocates at index 1
    @(negedge CLK); rs(JAL, 3'b000, 0, 0, 0, 32'h044, 32'h800, 1'b0, 32'h0);
    res("jal", 3'b011, 1'b1, 32'h800);
    @(negedge CLK); idle();
    fetch("jal_fetch", 32'h044, 1'b1, 32'h800);

    // JALR with wrong predicted target replaces the 0x100 entry (same index)
    @(negedge CLK); rs(JALR, 3'b000, 0, 0, 0, 32'h200, 32'h340, 1'b1, 32'h300);
    res("jalr", 3'b001, 1'b1, 32'h340);
    @(negedge CLK); idle();
    fetch("jalr_fetch", 32'h200, 1'b1, 32'h340);
    fetch("jalr_evict", 32'h100, 1'b0, 32'h104);

    // Aliasing: 0x140 evicts 0x100
    @(negedge CLK); rs(BR, 3'b000, 1, 0, 0, 32'h100, 32'h80, 1'b0, 32'h0);
    @(negedge CLK); rs(JAL, 3'b000, 0, 0, 0, 32'h140, 32'h500, 1'b0, 32'h0);
    res("alias_jal", 3'b011, 1'b1, 32'h500);
    @(negedge CLK); idle();
    fetch("alias_100", 32'h100, 1'b0, 32'h104);
    fetch("alias_140", 32'h140, 1'b1, 32'h500);

    // Same-cycle fetch and train of one index returns old contents
    @(negedge CLK); rs(JAL, 3'b000, 0, 0, 0, 32'h140, 32'h600, 1'b1, 32'h500);
    fetch("simul_old", 32'h140, 1'b1, 32'h500);
    res("simul", 3'b011, 1'b1, 32'h600);
    @(negedge CLK); idle();
    fetch("simul_new", 32'h140, 1'b1, 32'h600);

    // Wraparound of PC+4 on both sides
    @(negedge CLK); rs(BR, 3'b000, 0, 0, 0, 32'hFFFF_FFFC, 32'h80, 1'b1, 32'h80);
    fetch("wrap_fetch", 32'hFFFF_FFFC, 1'b0, 32'h0);
    res("wrap_res", 3'b000, 1'b1, 32'h0);

    // Async reset between edges, with a training request that must be cancelled
    @(negedge CLK); rs(JAL, 3'b000, 0, 0, 0, 32'h140, 32'h700, 1'b0, 32'h0);
    #1 RST = 1'b1;
    fetch("arst_140", 32'h140, 1'b0, 32'h144);
    fetch("arst_044", 32'h044, 1'b0, 32'h048);
    res("arst_res", 3'b011, 1'b1, 32'h700);
`ifdef BRANCH_PRED_PERF_EN
    chk("arst_perf_br", PERF_BR_CNT, 32'h0);
    chk("arst_perf_miss", PERF_MISS_CNT, 32'h0);
`endif
    @(negedge CLK); idle(); RST = 1'b0;
    @(negedge CLK);
    fetch("post_rst_140", 32'h140, 1'b0, 32'h144);
    fetch("post_rst_200", 32'h200, 1'b0, 32'h204);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_pred_unit.md
# branch_pred_unit

Parametrised next-PC unit combining a fetch-side branch predictor with execute-side branch resolution.
- **Fetch side:** a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters predicts direction and target for the fetch PC.
- **Execute side:** resolves conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU), JAL and JALR against the carried prediction. It produces the PC-source select, mispredict flush and redirect PC, and trains the table.
- Sits between the PC register/fetch stage and the execute stage of the pipelined OTTER.

## Interface
Parameters:
- XLEN, 32, PC/target width.
- ENTRIES, 16, BTB entries; power of two, 2..256.
- IDX_W, $clog2(ENTRIES), index width (derived, not overridden).
- TAG_W, XLEN-2-IDX_W, stored tag width (derived).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- F_PC  in  XLEN  fetch PC.
- F_PRED_TAKEN  out  1  predicted taken.
- F_PRED_TARGET  out  XLEN  predicted target; equals F_PC+4 when not predicted taken.
- R_VALID  in  1  resolve-stage instruction valid.
- R_OPCODE  in  7  instruction opcode.
- R_FUNCT  in  3  funct3.
- R_BR_EQ, R_BR_LT, R_BR_LTU  in  1 each  comparator flags.
- R_PC  in  XLEN  PC of resolving instruction.
- R_TARGET  in  XLEN  computed target (branch/JAL/JALR).
- R_PRED_TAKEN  in  1  prediction carried down the pipe.
- R_PRED_TARGET  in  XLEN  predicted target carried down the pipe.
- R_PC_SOURCE  out  3  actual-path select (see Operation).
- R_MISPREDICT  out  1  flush younger instructions.
- R_REDIRECT_PC  out  XLEN  correct next PC when R_MISPREDICT=1, else 0.

## Operation
- **Table entry:** valid bit, TAG_W tag, XLEN target, 2-bit counter.
  - Index = PC[IDX_W+1:2]; tag = PC[XLEN-1:IDX_W+2].
- **Fetch lookup:** combinational from registered table.
  - Hit = valid && tag match.
  - F_PRED_TAKEN = hit && counter[1].
- **Resolve taken rules (R_VALID=1):**
  - JAL (1101111): taken, R_PC_SOURCE=3'b011.
  - JALR (1100111): taken, 3'b001.
  - B-type (1100011): funct3 000 EQ, 001 !EQ, 100 LT, 101 !LT, 110 LTU, 111 !LTU.
    - Taken → 3'b010; not taken → 3'b000.
    - funct3 010/011 → not taken, 3'b000, no training.
  - Any other opcode, or R_VALID=0 → 3'b000, no mispredict, no training.
- **Mispredict:** actual_taken≠R_PRED_TAKEN, or actual_taken && R_PRED_TARGET≠R_TARGET.
  - Redirect = R_TARGET if actual taken, else R_PC+4 (predicted-taken-not-taken case).
- **Training** (rising edge, R_VALID=1, valid B-type/JAL/JALR):
  - Taken:
    - Write tag, R_TARGET, valid=1.
    - Counter: miss → 2'b10; hit → saturating increment (max 11).
  - Not taken B-type:
    - Hit → saturating decrement (min 00).
    - Miss → no write.
  - JAL/JALR always train as taken.
- **Arithmetic:** R_PC+4 and F_PC+4 wrap modulo 2^XLEN.

## Timing
- Fetch prediction and resolve outputs are combinational, same cycle.
- Table write takes effect at the next rising edge. Fetch reading the index being trained in the same cycle sees the old contents.
- **Reset:**
  - Asynchronous; all valid bits 0, counters 2'b01, tags/targets 0.
  - Performance counters 0.
  - During reset: F_PRED_TAKEN=0, F_PRED_TARGET=F_PC+4. R_* outputs follow the combinational rules (the reset-only predicted state is not-taken).
  - RST asserted mid-training cancels the write.
- **Aliasing:** entries with different tags at the same index overwrite each other (no associativity).

## Configuration
- **BRANCH_PRED_PERF_EN defined:** adds outputs PERF_BR_CNT and PERF_MISS_CNT (32 bits each).
  - PERF_BR_CNT increments on each trained resolve.
  - PERF_MISS_CNT increments on each R_MISPREDICT.
  - Both wrap at 2^32 and clear on RST.
- **Undefined:** ports and counters are absent; behaviour is otherwise identical.

## Test plan
- **Reset, then lookup:** F_PC=0x100 → F_PRED_TAKEN=0, F_PRED_TARGET=0x104.
- **Taken-branch training:** BEQ at R_PC=0x100, R_BR_EQ=1, R_TARGET=0x80, R_PRED_TAKEN=0.
  - Same cycle: R_PC_SOURCE=010, R_MISPREDICT=1, redirect 0x80.
  - Next cycle: F_PC=0x100 → taken, target 0x80.
- **Counter saturation:** three more taken BEQ at 0x100 → counter 11.
  - Then two not-taken → counter 01; fetch predicts not taken.
  - Second not-taken: R_PRED_TAKEN=1 → R_MISPREDICT=1, redirect 0x104.
- **JALR target change:** JALR at 0x200, predicted target 0x300, actual R_TARGET=0x340.
  - R_PC_SOURCE=001, R_MISPREDICT=1, redirect 0x340.
  - Table target updated to 0x340.
- **Alias and simultaneous access:**
  - ENTRIES=16: train 0x100 then 0x140 (same index) → 0x100 misses.
  - Same-cycle fetch/train of one index → old value returned.
- **Async RST mid-stream:** assert RST between edges → all predictions clear immediately. With BRANCH_PRED_PERF_EN, both counters read 0.
